imem_fetch_port: RTL and testbench
==================================

// Module: imem_fetch_port
// PURPOSE
//  Parametrised synchronous instruction memory with a valid/ready fetch port and a word-write program-load port.
//  Replaces the hard-wired combinational ROM. Sits between the core's fetch stage and the instruction array.
//  Read latency is one cycle, with full back-to-back throughput.
//  Misaligned and out-of-range fetches are flagged as faults and return a NOP.
// PARAMETERS
//  DATA_W     32            instruction word width (bits)
//  ADDR_W     32            fetch byte-address width
//  DEPTH      1024          number of instruction words; must be a power of two, >= 2
//  BASE_ADDR  32'h0000_0000 byte address of word 0; must be DATA_W/8 aligned
//  NOP_INST   32'h00000013  word returned on a faulting fetch (addi x0,x0,0)
//  IDX_W      $clog2(DEPTH) derived word-index width; do not override
// PORTS
//  clk           in   1       single clock; all logic is rising-edge
//  rst           in   1       asynchronous reset, active-high
//  req_valid     in   1       fetch request present
//  req_ready     out  1       fetch request can be accepted this cycle
//  req_addr      in   ADDR_W  fetch byte address
//  rsp_valid     out  1       fetch response present
//  rsp_ready     in   1       consumer takes the response this cycle
//  rsp_inst      out  DATA_W  fetched instruction, or NOP_INST on fault
//  rsp_fault     out  1       response corresponds to a faulting address
//  load_en       in   1       program-load mode; blocks new fetches
//  load_we       in   1       write strobe; honoured only while load_en=1
//  load_idx      in   IDX_W   word index to write
//  load_data     in   DATA_W  word to write
// BEHAVIOUR
//  - Reset (async assert, sync release): rsp_valid=0, rsp_inst=0, rsp_fault=0.
//    req_ready follows the combinational rule below, so it is 1 when load_en=0.
//    Array contents are not reset.
//  - Two-state FSM: EMPTY (no response held) and FULL (response held).
//  - req_ready = !load_en && (state==EMPTY || rsp_ready). Purely combinational; it never depends on req_valid.
//  - Accept condition: req_valid && req_ready at a rising edge. On the next edge-registered cycle:
//    - state=FULL, rsp_valid=1;
//    - rsp_inst = array[idx], or NOP_INST if faulting;
//    - rsp_fault set accordingly.
//  - Index and fault computation, with off = req_addr - BASE_ADDR (ADDR_W-bit modular arithmetic):
//    - idx = off >> log2(DATA_W/8);
//    - fault if off[log2(DATA_W/8)-1:0] != 0, OR if off >= DEPTH*(DATA_W/8) (unsigned compare, covers wrap below BASE_ADDR).
//  - FSM transitions:
//    - FULL && rsp_ready && accept:  stays FULL, new data; throughput 1 fetch/cycle.
//    - FULL && rsp_ready && !accept: -> EMPTY, rsp_valid=0.
//    - FULL && !rsp_ready:           hold rsp_inst and rsp_fault stable; no accept possible.
//    - EMPTY && accept:              -> FULL.
//  - Held response is not affected by later array writes; it is the value read at the accept edge.
//  - Load port: when load_en && load_we at an edge, array[load_idx] <= load_data. Writes are synchronous.
//  - Write timing: a write at edge N is visible to a fetch accepted at edge N+1 or later.
//  - Fetch/load conflicts:
//    - load_en=1 forces req_ready=0, so no fetch and write can share an edge.
//    - A response already held when load_en rises is still delivered normally.
//  - load_we with load_en=0 is ignored.
//  - Reset mid-operation: any held response is dropped (rsp_valid=0 immediately on rst assert); array preserved.
//  - Array is inferred as a synchronous-read RAM with a single write port; no combinational array read reaches rsp_*.
// TESTING
//  1 Reset release, then load words 0..3 = 32'hfe010113, 32'h00112e23, 32'h00812c23, 32'h02010413.
//    Fetch 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1
//    -> rsp_valid high 4 consecutive cycles starting 1 cycle after first accept; data in order; rsp_fault=0.
//  2 Fetch 0x4 with rsp_ready=0 for 3 cycles, req_valid held on 0x8
//    -> rsp_inst=32'h00112e23 stable, req_ready=0.
//    Then rsp_ready=1 -> 0x8 accepted same edge; next rsp_inst=32'h00812c23.
//  3 Fetch 0x6 -> rsp_fault=1, rsp_inst=32'h00000013.
//    Fetch DEPTH*4 (0x1000 at default) -> fault+NOP.
//    With BASE_ADDR=0x100, fetch 0x0FC -> fault.
//  4 load_en=1 while a response is held -> response delivered unchanged; req_ready=0 throughout load.
//    Write idx 1 = 32'hdeadbeef, drop load_en, fetch 0x4 -> 32'hdeadbeef.
//    load_we pulsed with load_en=0 -> no change.
//  5 Assert rst asynchronously mid-cycle with rsp_valid=1 -> rsp_valid=0 before next edge.
//    After release, fetch 0x0 -> previously loaded word still returned.
//  6 Random valid/ready stalls, 10k fetches vs. scoreboard model -> no dropped, duplicated or reordered responses.

Source files
------------

// File: rtl/imem_fetch_port.sv
// Instruction memory with a one-cycle synchronous-read fetch port (valid/ready)
// and a word-write program-load port. Faulting fetches return NOP_INST.
module imem_fetch_port #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter int                 DEPTH     = 1024,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h0000_0000,
    parameter logic [DATA_W-1:0]  NOP_INST  = 32'h0000_0013,
    parameter int                 IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_inst,
    output logic              rsp_fault,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [DATA_W-1:0] load_data
);

    localparam int                BYTES      = DATA_W / 8;
    localparam int                OFF_LSB    = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   LIMIT      = (ADDR_W + 1)'(DEPTH * BYTES);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              fault_q;
    logic              has_data_q;
    logic [ADDR_W-1:0] off_s;
    logic [IDX_W-1:0]  idx_s;
    logic              fault_s;
    logic              accept_s;

    // The offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land far out of range.
    assign off_s    = req_addr - BASE_ADDR;
    assign idx_s    = off_s[OFF_LSB +: IDX_W];
    assign fault_s  = ((off_s & ALIGN_MASK) != '0) || ({1'b0, off_s} >= LIMIT);
    assign req_ready = !load_en && ((state_q == ST_EMPTY) || rsp_ready);
    assign accept_s  = req_valid && req_ready;

    // Program-load write port.
    always_ff @(posedge clk) begin
        if (load_en && load_we) begin
            mem_q[load_idx] <= load_data;
        end
    end

    // Synchronous array read, captured only at an accept so a held response stays frozen.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            rd_q <= mem_q[idx_s];
        end
    end

    // Next-state logic for the single response slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !accept_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Response control state; has_data_q keeps rsp_inst at zero until the first accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            fault_q    <= 1'b0;
            has_data_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                fault_q    <= fault_s;
                has_data_q <= 1'b1;
            end
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_fault = fault_q;
    assign rsp_inst  = !has_data_q ? '0 : (fault_q ? NOP_INST : rd_q);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed and randomly-stalled checks of imem_fetch_port against hand-computed values.
module tb_imem_fetch_port;

    localparam logic [31:0] W0  = 32'hfe010113;
    localparam logic [31:0] W1  = 32'h00112e23;
    localparam logic [31:0] W2  = 32'h00812c23;
    localparam logic [31:0] W3  = 32'h02010413;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] DB  = 32'hdeadbeef;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, rsp_ready = 1'b1, load_en = 1'b0, load_we = 1'b0;
    logic [31:0] req_addr = 32'h0, load_data = 32'h0;
    logic [9:0]  load_idx = 10'd0;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_inst;

    logic        req_valid2 = 1'b0;
    logic [31:0] req_addr2 = 32'h0;
    logic        req_ready2, rsp_valid2, rsp_fault2;
    logic [31:0] rsp_inst2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imem_fetch_port dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_fault(rsp_fault),
        .load_en(load_en), .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
    );

    imem_fetch_port #(.DEPTH(16), .BASE_ADDR(32'h0000_0100)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
        .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_inst(rsp_inst2), .rsp_fault(rsp_fault2),
        .load_en(1'b0), .load_we(1'b0), .load_idx(4'd0), .load_data(32'h0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mdl [4];

    function automatic logic [32:0] expect_rsp(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a >= 32'h0000_1000) return {1'b1, NOP};
        if (a < 32'h10) return {1'b0, mdl[a[3:2]]};
        return {1'b0, 32'h0};
    endfunction

    logic [32:0] q[$];
    logic [32:0] e;
    logic [31:0] addrs [7];

    initial begin
        mdl[0] = W0; mdl[1] = DB; mdl[2] = W2; mdl[3] = W3;
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
        addrs[4] = 32'h6; addrs[5] = 32'h1000; addrs[6] = 32'h2;

        // 1: reset state, program load, back-to-back fetch
        tick(); tick();
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_inst", rsp_inst, 32'h0);
        chk("rst_fault", rsp_fault, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        @(negedge clk); rst = 1'b0;
        tick();
        load_en = 1'b1; load_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_idx = 10'(i);
            load_data = (i == 0) ? W0 : (i == 1) ? W1 : (i == 2) ? W2 : W3;
            #1 chk("load_ready", req_ready, 1'b0);
            tick();
        end
        load_en = 1'b0; load_we = 1'b0;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        #1 chk("b2b_pre_valid", rsp_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            req_addr = 32'(4 * (i + 1));
            if (i == 3) req_valid = 1'b0;
            chk("b2b_valid", rsp_valid, 1'b1);
            chk("b2b_inst", rsp_inst, (i == 0) ? W0 : (i == 1) ? W1 : (i == 2) ? W2 : W3);
            chk("b2b_fault", rsp_fault, 1'b0);
        end
        tick();
        chk("b2b_end_valid", rsp_valid, 1'b0);

        // 2: back-pressure hold, then same-edge accept
        req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
        tick();
        req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_ready", req_ready, 1'b0);
            chk("hold_inst", rsp_inst, W1);
            chk("hold_valid", rsp_valid, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("release_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("release_inst", rsp_inst, W2);
        tick();
        chk("release_empty", rsp_valid, 1'b0);

        // 3: faults on misalignment, range end, and below a non-zero base
        req_valid = 1'b1; req_addr = 32'h6;
        tick();
        chk("mis_fault", rsp_fault, 1'b1);
        chk("mis_inst", rsp_inst, NOP);
        req_addr = 32'h1000;
        tick();
        chk("oor_fault", rsp_fault, 1'b1);
        chk("oor_inst", rsp_inst, NOP);
        req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        chk("post_fault_clear", rsp_fault, 1'b0);
        chk("post_fault_inst", rsp_inst, W2);
        tick();
        req_valid2 = 1'b1; req_addr2 = 32'h0FC;
        tick();
        chk("base_below_fault", rsp_fault2, 1'b1);
        chk("base_below_inst", rsp_inst2, NOP);
        req_addr2 = 32'h100;
        tick();
        chk("base_first_fault", rsp_fault2, 1'b0);
        req_addr2 = 32'h140;
        tick();
        chk("base_end_fault", rsp_fault2, 1'b1);
        req_addr2 = 32'h13C;
        tick();
        req_valid2 = 1'b0;
        chk("base_last_fault", rsp_fault2, 1'b0);
        chk("base_valid", rsp_valid2, 1'b1);

        // 4: load while a response is held; write visibility; ignored write
        req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        load_en = 1'b1; load_we = 1'b1; load_idx = 10'd1; load_data = DB;
        #1 chk("ld_ready0", req_ready, 1'b0);
        tick();
        load_we = 1'b0;
        chk("ld_held_inst", rsp_inst, W1);
        chk("ld_held_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        #1 chk("ld_ready1", req_ready, 1'b0);
        tick();
        chk("ld_delivered", rsp_valid, 1'b0);
        chk("ld_ready2", req_ready, 1'b0);
        load_en = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        chk("ld_new_word", rsp_inst, DB);
        load_we = 1'b1; load_idx = 10'd1; load_data = 32'h12345678;
        tick();
        load_we = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        chk("we_ignored", rsp_inst, DB);
        tick();

        // 5: async reset mid-cycle drops the held response, array survives
        req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_valid", rsp_valid, 1'b1);
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", rsp_valid, 1'b0);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("post_rst_valid", rsp_valid, 1'b0);
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        chk("post_rst_inst", rsp_inst, W0);
        tick();

        // 6: random valid/ready stalls against a single-slot model
        begin
            int  n_acc = 0, n_del = 0;
            bit  m_full = 1'b0;
            bit  rv, rr, exp_rdy, acc;
            while (n_acc < 10000) begin
                rv = ($urandom % 4) != 0;
                rr = ($urandom % 3) != 0;
                req_valid = rv; rsp_ready = rr;
                req_addr = addrs[$urandom % 7];
                #1;
                exp_rdy = !m_full || rr;
                chk("rnd_ready", req_ready, exp_rdy);
                chk("rnd_valid", rsp_valid, m_full);
                if (m_full && rr) begin
                    if (q.size() == 0) begin
                        chk("rnd_underflow", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rnd_inst", rsp_inst, e[31:0]);
                        chk("rnd_fault", rsp_fault, e[32]);
                        n_del++;
                    end
                end
                acc = rv && exp_rdy;
                if (acc) begin
                    q.push_back(expect_rsp(req_addr));
                    n_acc++;
                end
                m_full = acc ? 1'b1 : (rr ? 1'b0 : m_full);
                tick();
            end
            req_valid = 1'b0; rsp_ready = 1'b1;
            #1;
            if (m_full && q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_last_inst", rsp_inst, e[31:0]);
                n_del++;
            end
            tick();
            chk("rnd_drained", rsp_valid, 1'b0);
            chk("rnd_count", 32'(n_del), 32'(n_acc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
